// File: rtl/tt_proj_mux_ctrl.sv
// Chip-side multi-project mux controller: decodes inc/rst select pads into an address and
// drives a one-hot project enable after a settle period. Option: TT_MUX_OUT_REG_EN registers pad outputs.
module tt_proj_mux_ctrl #(
    parameter int unsigned N_PROJ     = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_inc,
    input  logic                 ctrl_rst,
    input  logic                 pad_rst_n,
    input  logic [7:0]           pad_ui_in,
    input  logic [7:0]           pad_uio_in,
    input  logic [N_PROJ*24-1:0] ow_bus,
    output logic [17:0]          iw,
    output logic [N_PROJ-1:0]    ena,
    output logic [7:0]           uo_out,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic [ADDR_W-1:0]    sel_addr,
    output logic                 active
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned IDX_W = (N_PROJ > 1) ? $clog2(N_PROJ) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StActive
    } state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N_PROJ-1:0] ena_q, ena_d;
    logic [2:0]        inc_sync_q, rst_sync_q;
    logic              inc_edge, rst_edge, sel_evt;
    logic              proj_rst_n;
    logic [23:0]       out_sel;
    logic [IDX_W-1:0]  out_idx;
    logic [23:0]       ow_slice [N_PROJ];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < N_PROJ;
    endfunction

    // Bit 0/1 form the 2-FF synchronizer; bit 2 holds the previous level for edge detection.
    assign inc_edge = inc_sync_q[1] & ~inc_sync_q[2];
    assign rst_edge = rst_sync_q[1] & ~rst_sync_q[2];
    assign sel_evt  = inc_edge | rst_edge;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ena_d   = '0;

        if (rst_edge) begin
            addr_d = '0;
        end else if (inc_edge) begin
            addr_d = addr_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (sel_evt) begin
                    state_d = StSettle;
                    cnt_d   = CNT_LOAD;
                end
            end
            StSettle: begin
                if (sel_evt) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StActive: begin
                if (sel_evt) begin
                    state_d = StSettle;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: state_d = StIdle;
        endcase

        // Derived from next state so ena falls on the same edge a new select arrives.
        if (state_d == StActive && in_range(addr_d)) begin
            ena_d[IDX_W'(addr_d)] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_sync_q <= '0;
            rst_sync_q <= '0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            ena_q      <= '0;
        end else begin
            inc_sync_q <= {inc_sync_q[1:0], ctrl_inc};
            rst_sync_q <= {rst_sync_q[1:0], ctrl_rst};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ena_q      <= ena_d;
        end
    end

    assign active     = (state_q == StActive);
    assign sel_addr   = addr_q;
    assign ena        = ena_q;
    assign proj_rst_n = pad_rst_n & active;
    assign iw         = {pad_uio_in, pad_ui_in, proj_rst_n, clk};

    for (genvar p = 0; p < N_PROJ; p++) begin : g_slice
        assign ow_slice[p] = ow_bus[24*p +: 24];
    end

    assign out_idx = in_range(addr_q) ? IDX_W'(addr_q) : '0;
    assign out_sel = (active && in_range(addr_q)) ? ow_slice[out_idx] : 24'h0;

`ifdef TT_MUX_OUT_REG_EN
    logic [23:0] out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_sel;
        end
    end

    assign {uio_oe, uio_out, uo_out} = out_q;
`else
    assign {uio_oe, uio_out, uo_out} = out_sel;
`endif

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Randomized bench for tt_proj_mux_ctrl (N_PROJ=12) against a cycle-count reference model,
// plus directed select scenarios with literal expectations.
module tb_tt_proj_mux_ctrl;

    localparam int N = 12;
    localparam int A = 4;
    localparam int S = 4;

    logic          clk, rst;
    logic          ctrl_inc, ctrl_rst, pad_rst_n;
    logic [7:0]    pad_ui_in, pad_uio_in;
    logic [N*24-1:0] ow_bus;
    logic [17:0]   iw;
    logic [N-1:0]  ena;
    logic [7:0]    uo_out, uio_out, uio_oe;
    logic [A-1:0]  sel_addr;
    logic          active;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    tt_proj_mux_ctrl #(
        .N_PROJ    (N),
        .ADDR_W    (A),
        .SETTLE_CYC(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_inc  (ctrl_inc),
        .ctrl_rst  (ctrl_rst),
        .pad_rst_n (pad_rst_n),
        .pad_ui_in (pad_ui_in),
        .pad_uio_in(pad_uio_in),
        .ow_bus    (ow_bus),
        .iw        (iw),
        .ena       (ena),
        .uo_out    (uo_out),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .sel_addr  (sel_addr),
        .active    (active)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a pad level seen at posedge j becomes a select event at posedge j+2;
    // enable follows once S cycles have elapsed since the latest event.
    logic [2:0]  inc_h, rst_h;
    int          m_addr, m_since;
    bit          m_started;
    logic [23:0] m_out_q;
    logic        m_act;
    logic [N-1:0] exp_ena;
    logic [23:0] exp_out_now, exp_out;
    logic [N-1:0] one;

    assign one         = 1;
    assign m_act       = m_started && (m_since >= S);
    assign exp_ena     = (m_act && m_addr < N) ? (one << m_addr) : '0;
    assign exp_out_now = (m_act && m_addr < N) ? ow_bus[24*m_addr +: 24] : 24'h0;
`ifdef TT_MUX_OUT_REG_EN
    assign exp_out = m_out_q;
`else
    assign exp_out = exp_out_now;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_h     <= '0;
            rst_h     <= '0;
            m_addr    <= 0;
            m_since   <= 0;
            m_started <= 0;
            m_out_q   <= '0;
        end else begin
            m_out_q <= exp_out_now;
            if (rst_h[1] && !rst_h[2]) m_addr <= 0;
            else if (inc_h[1] && !inc_h[2]) m_addr <= (m_addr + 1) % 16;
            if ((rst_h[1] && !rst_h[2]) || (inc_h[1] && !inc_h[2])) begin
                m_started <= 1;
                m_since   <= 0;
            end else if (m_since < S) begin
                m_since <= m_since + 1;
            end
            inc_h <= {inc_h[1:0], ctrl_inc};
            rst_h <= {rst_h[1:0], ctrl_rst};
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en && !rst) begin
            check("sel_addr", sel_addr, 64'(m_addr % 16));
            check("active", active, m_act);
            check("ena", ena, exp_ena);
            check("pad_out", {uio_oe, uio_out, uo_out}, exp_out);
            check("iw", iw, {pad_uio_in, pad_ui_in, pad_rst_n & m_act, 1'b1});
        end
    end

    task automatic pulse(input bit do_inc, input bit do_rst, input int hi, input int lo);
        @(negedge clk);
        ctrl_inc = do_inc;
        ctrl_rst = do_rst;
        repeat (hi) @(negedge clk);
        ctrl_inc = 0;
        ctrl_rst = 0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic select(input int p);
        pulse(0, 1, 2, 2);
        for (int i = 0; i < p; i++) pulse(1, 0, 2, 2);
        repeat (S + 2) @(negedge clk);
    endtask

    task automatic rand_ow();
        for (int p = 0; p < N; p++) ow_bus[24*p +: 24] = 24'($urandom);
    endtask

    initial begin
        rst        = 1;
        ctrl_inc   = 0;
        ctrl_rst   = 0;
        pad_rst_n  = 1;
        pad_ui_in  = 8'($urandom);
        pad_uio_in = 8'($urandom);
        rand_ow();
        repeat (3) @(negedge clk);
        check("rst_sel_addr", sel_addr, 0);
        check("rst_ena", ena, 0);
        check("rst_active", active, 0);
        check("rst_out", {uio_oe, uio_out, uo_out}, 0);
        check("rst_iw1", iw[1], 0);
        rst    = 0;
        chk_en = 1;
        repeat (4) @(negedge clk);
        check("idle_ena", ena, 0);

        // First increment selects project 1.
        pulse(1, 0, 2, 2);
        repeat (S + 2) @(negedge clk);
        check("inc1_addr", sel_addr, 1);
        check("inc1_ena", ena, 12'h002);
        check("inc1_active", active, 1);

        // Project 3 output routing.
        for (int p = 0; p < N; p++) ow_bus[24*p +: 24] = 24'hFFFFFF;
        ow_bus[24*3 +: 24] = 24'hA53C7E;
        select(3);
        check("p3_uio_oe", uio_oe, 8'hA5);
        check("p3_uio_out", uio_out, 8'h3C);
        check("p3_uo_out", uo_out, 8'h7E);

        // Out-of-range address, then wrap.
        select(13);
        check("oor_addr", sel_addr, 13);
        check("oor_ena", ena, 0);
        check("oor_out", {uio_oe, uio_out, uo_out}, 0);
        check("oor_active", active, 1);
        for (int i = 0; i < 3; i++) pulse(1, 0, 2, 2);
        repeat (S + 2) @(negedge clk);
        check("wrap_addr", sel_addr, 0);
        check("wrap_ena", ena, 12'h001);

        // Simultaneous inc and rst: rst wins, ena drops on the update edge.
        select(5);
        check("p5_ena", ena, 12'h020);
        @(negedge clk);
        ctrl_inc = 1;
        ctrl_rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("both_addr", sel_addr, 0);
        check("both_ena", ena, 0);
        @(negedge clk);
        ctrl_inc = 0;
        ctrl_rst = 0;
        repeat (S + 2) @(negedge clk);
        check("both_ena_after", ena, 12'h001);

        // Restart mid-settle.
        pulse(1, 0, 2, 2);
        pulse(1, 0, 2, 2);
        repeat (S + 2) @(negedge clk);
        check("restart_ena", ena, 12'h004);

        // Async reset while active on project 7.
        select(7);
        check("p7_ena", ena, 12'h080);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("arst_ena", ena, 0);
        check("arst_addr", sel_addr, 0);
        check("arst_out", {uio_oe, uio_out, uo_out}, 0);
        check("arst_iw1", iw[1], 0);
        @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        check("post_rst_iw1", iw[1], 0);
        check("post_rst_active", active, 0);

        // Randomized select traffic checked cycle by cycle against the model.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) rand_ow();
            pad_ui_in  = 8'($urandom);
            pad_uio_in = 8'($urandom);
            pad_rst_n  = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 5))
                0, 1, 2: pulse(1, 0, $urandom_range(2, 4), $urandom_range(2, 5));
                3:       pulse(0, 1, $urandom_range(2, 4), $urandom_range(2, 5));
                4:       pulse(1, 1, $urandom_range(2, 4), $urandom_range(2, 5));
                default: repeat ($urandom_range(1, 8)) @(negedge clk);
            endcase
        end
        repeat (S + 4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
